// File: rtl/seg7_display_arbiter_pkg.sv
// Shared definitions for the two-requester 7-segment display arbiter:
// FSM encoding, blank pattern, display modes and the hex glyph table.
package seg7_display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Active-low pattern with every segment off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] MODE_HEX  = 2'd0;
  localparam logic [1:0] MODE_DEC  = 2'd1;
  localparam logic [1:0] MODE_EVEN = 2'd2;
  localparam logic [1:0] MODE_SPIN = 2'd3;

  // Active-high segments a..g, bit 6 = a
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_display_arbiter_if.sv
// Request/data/display bundle between the requesters (master) and the
// display arbiter (slave).
interface seg7_display_arbiter_if;
  logic [1:0] i_req;
  logic [7:0] i_data0;
  logic [7:0] i_data1;
  logic [1:0] i_mode0;
  logic [1:0] i_mode1;
  logic [1:0] i_blink;
  logic [1:0] o_gnt;
  logic       o_busy;
  logic [6:0] o_seg1;
  logic [6:0] o_seg2;

  modport master (
    output i_req, i_data0, i_data1, i_mode0, i_mode1, i_blink,
    input  o_gnt, o_busy, o_seg1, o_seg2
  );

  modport slave (
    input  i_req, i_data0, i_data1, i_mode0, i_mode1, i_blink,
    output o_gnt, o_busy, o_seg1, o_seg2
  );
endinterface

// File: rtl/binary_to_7segment.sv
// Combinational nibble-to-segment decoder, active-high outputs (bit 6 = a).
// DEC blanks A..F, EVEN blanks odd values, SPIN lights one of a..f by value mod 6.
module binary_to_7segment
  import seg7_display_arbiter_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic [1:0] mode_i,
  output logic [6:0] seg_o
);

  logic [6:0] glyph;
  logic [3:0] spin_pos;

  always_comb begin
    glyph    = hex_glyph(nibble_i);
    spin_pos = nibble_i % 4'd6;
    seg_o    = glyph;
    case (mode_i)
      MODE_HEX:  seg_o = glyph;
      MODE_DEC:  seg_o = (nibble_i > 4'd9) ? 7'h00 : glyph;
      MODE_EVEN: seg_o = nibble_i[0] ? 7'h00 : glyph;
      MODE_SPIN: seg_o = 7'h40 >> spin_pos;
      default:   seg_o = glyph;
    endcase
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter granting one of two requesters a timed slot on a
// two-digit 7-segment display. Define SEG7_BLINK_EN to enable digit blinking.
module seg7_display_arbiter
  import seg7_display_arbiter_pkg::*;
#(
  parameter int DWELL_CYCLES = 25000000,
  parameter int BLINK_CYCLES = 6250000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  seg7_display_arbiter_if.slave bus
);

  localparam int DWELL_EFF = (DWELL_CYCLES < 1) ? 1 : DWELL_CYCLES;
  localparam int CNT_W     = $clog2(DWELL_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_EFF - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic [1:0]       gnt_q;
  logic             busy_q;

  logic [7:0]       data_q;
  logic [1:0]       mode_q;
  logic             win_d;
  logic [7:0]       data_d;
  logic [1:0]       mode_d;
  logic [6:0]       tens_d;
  logic [6:0]       ones_d;
  logic             show_d;
  logic [6:0]       dec1_q;
  logic [6:0]       dec2_q;
  logic [6:0]       seg1_q;
  logic [6:0]       seg2_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // A tie goes to whoever was not served last; a lone request always wins
  always_comb begin
    win_d  = (bus.i_req == 2'b11) ? ~last_q : bus.i_req[1];
    data_d = win_d ? bus.i_data1 : bus.i_data0;
    mode_d = win_d ? bus.i_mode1 : bus.i_mode0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      gnt_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (|bus.i_req) begin
            state_q <= ST_LOAD;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            last_q  <= win_d;
          end
        end
        ST_LOAD: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
        end
        ST_HOLD: begin
          if (cnt_q == CNT_MAX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BLINK_EFF = (BLINK_CYCLES < 1) ? 1 : BLINK_CYCLES;
  localparam int BLK_W     = $clog2(BLINK_EFF + 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_EFF - 1);

  logic [BLK_W-1:0] blk_cnt_q;
  logic             blk_phase_q;
  logic             blink_q;

  // Phase 0 is the visible half; each HOLD starts visible
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      blk_cnt_q   <= '0;
      blk_phase_q <= 1'b0;
    end else if (state_q != ST_HOLD) begin
      blk_cnt_q   <= '0;
      blk_phase_q <= 1'b0;
    end else if (blk_cnt_q == BLK_MAX) begin
      blk_cnt_q   <= '0;
      blk_phase_q <= ~blk_phase_q;
    end else begin
      blk_cnt_q <= blk_cnt_q + 1'b1;
    end
  end

  assign show_d = (state_q != ST_IDLE) &&
                  !((state_q == ST_HOLD) && blink_q && blk_phase_q);
`else
  logic [33:0] unused_blink;
  assign unused_blink = {bus.i_blink, 32'(BLINK_CYCLES)};
  assign show_d       = (state_q != ST_IDLE);
`endif

  // Winner's payload is captured on the edge that enters LOAD
  always_ff @(posedge i_clk) begin
    if ((state_q == ST_IDLE) && (|bus.i_req)) begin
      data_q  <= data_d;
      mode_q  <= mode_d;
`ifdef SEG7_BLINK_EN
      blink_q <= bus.i_blink[win_d];
`endif
    end
  end

  binary_to_7segment u_dec_tens (
    .nibble_i (data_q[7:4]),
    .mode_i   (mode_q),
    .seg_o    (tens_d)
  );

  binary_to_7segment u_dec_ones (
    .nibble_i (data_q[3:0]),
    .mode_i   (mode_q),
    .seg_o    (ones_d)
  );

  // Stage 1: decoded and inverted; stage 2: output register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dec1_q <= SEG_BLANK;
      dec2_q <= SEG_BLANK;
      seg1_q <= SEG_BLANK;
      seg2_q <= SEG_BLANK;
    end else begin
      dec1_q <= show_d ? ~tens_d : SEG_BLANK;
      dec2_q <= show_d ? ~ones_d : SEG_BLANK;
      seg1_q <= dec1_q;
      seg2_q <= dec2_q;
    end
  end

  assign bus.o_gnt  = gnt_q;
  assign bus.o_busy = busy_q;
  assign bus.o_seg1 = seg1_q;
  assign bus.o_seg2 = seg2_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with DWELL_CYCLES=8, BLINK_CYCLES=2;
// blink expectations follow SEG7_BLINK_EN.
module tb_seg7_display_arbiter;
  import seg7_display_arbiter_pkg::*;

`ifdef SEG7_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  // Active-low glyphs for the digits used below
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] S1 = 7'h4F;
  localparam logic [6:0] S2 = 7'h12;
  localparam logic [6:0] S3 = 7'h06;
  localparam logic [6:0] S4 = 7'h4C;
  localparam logic [6:0] S5 = 7'h24;
  localparam logic [6:0] SA = 7'h08;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seg7_display_arbiter_if bus ();

  seg7_display_arbiter #(
    .DWELL_CYCLES (8),
    .BLINK_CYCLES (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(input int budget, input string tag, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.o_gnt != 2'b00) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  // Grant seen at k=0 (LOAD); k=1..8 HOLD, k=9 IDLE; segments lag by two cycles
  task automatic run_grant(input string tag, input logic [1:0] exp_gnt,
                           input logic [6:0] s1, input logic [6:0] s2,
                           input int budget, input bit blink_exp,
                           input bit perturb, input bit release_req);
    bit seen;
    bit vis;
    wait_gnt(budget, tag, seen);
    check_eq({tag, "_gnt"}, 32'(bus.o_gnt), 32'(exp_gnt));
    check_eq({tag, "_busy_load"}, 32'(bus.o_busy), 32'd1);
    if (release_req) bus.i_req = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (perturb && k == 3) begin
        bus.i_data1 = 8'hFF;
        bus.i_mode1 = MODE_SPIN;
        bus.i_blink = 2'b11;
      end
      vis = (k >= 2) && !(blink_exp && BLINK_ON && (k == 5 || k == 6 || k == 9));
      check_eq($sformatf("%s_gnt_k%0d", tag, k), 32'(bus.o_gnt), 32'd0);
      check_eq($sformatf("%s_busy_k%0d", tag, k), 32'(bus.o_busy), 32'(k <= 8));
      check_eq($sformatf("%s_seg1_k%0d", tag, k), 32'(bus.o_seg1), 32'(vis ? s1 : BL));
      check_eq($sformatf("%s_seg2_k%0d", tag, k), 32'(bus.o_seg2), 32'(vis ? s2 : BL));
    end
  endtask

  initial begin
    bit seen;
    rst_n       = 1'b0;
    bus.i_req   = 2'b00;
    bus.i_data0 = 8'h00;
    bus.i_data1 = 8'h00;
    bus.i_mode0 = MODE_HEX;
    bus.i_mode1 = MODE_HEX;
    bus.i_blink = 2'b00;

    repeat (3) @(negedge clk);
    check_eq("rst_seg1", 32'(bus.o_seg1), 32'(BL));
    check_eq("rst_seg2", 32'(bus.o_seg2), 32'(BL));
    check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
    check_eq("rst_gnt", 32'(bus.o_gnt), 32'd0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_seg1", 32'(bus.o_seg1), 32'(BL));
    check_eq("idle_seg2", 32'(bus.o_seg2), 32'(BL));
    check_eq("idle_busy", 32'(bus.o_busy), 32'd0);

    // Requester 0 alone, "3A" in hex mode, blink requested
    bus.i_data0 = 8'h3A;
    bus.i_mode0 = MODE_HEX;
    bus.i_blink = 2'b01;
    bus.i_req   = 2'b01;
    run_grant("single0", 2'b01, S3, SA, 20, 1'b1, 1'b0, 1'b1);
    bus.i_blink = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("after0_seg1", 32'(bus.o_seg1), 32'(BL));
    check_eq("after0_seg2", 32'(bus.o_seg2), 32'(BL));

    // Requester 1 alone; its inputs change mid-HOLD and must be ignored
    bus.i_data1 = 8'h45;
    bus.i_mode1 = MODE_HEX;
    bus.i_req   = 2'b10;
    run_grant("hold1", 2'b10, S4, S5, 20, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a HOLD aborts it and re-arms the tie pointer
    bus.i_data0 = 8'h12;
    bus.i_mode0 = MODE_HEX;
    bus.i_data1 = 8'h45;
    bus.i_mode1 = MODE_HEX;
    bus.i_blink = 2'b00;
    bus.i_req   = 2'b01;
    wait_gnt(20, "pre_rst", seen);
    check_eq("pre_rst_gnt", 32'(bus.o_gnt), 32'd1);
    repeat (3) @(negedge clk);
    bus.i_req = 2'b11;
    rst_n     = 1'b0;
    @(negedge clk);
    check_eq("midrst_seg1", 32'(bus.o_seg1), 32'(BL));
    check_eq("midrst_seg2", 32'(bus.o_seg2), 32'(BL));
    check_eq("midrst_busy", 32'(bus.o_busy), 32'd0);
    check_eq("midrst_gnt", 32'(bus.o_gnt), 32'd0);
    @(negedge clk);
    check_eq("midrst_gnt2", 32'(bus.o_gnt), 32'd0);
    rst_n = 1'b1;

    // Both held: 01, 10, 01 with one IDLE cycle between slots
    run_grant("rr0", 2'b01, S1, S2, 3, 1'b0, 1'b0, 1'b0);
    run_grant("rr1", 2'b10, S4, S5, 1, 1'b0, 1'b0, 1'b0);
    run_grant("rr2", 2'b01, S1, S2, 1, 1'b0, 1'b0, 1'b1);

    // Decoder modes
    bus.i_data1 = 8'h3A;
    bus.i_mode1 = MODE_DEC;
    bus.i_req   = 2'b10;
    run_grant("dec1", 2'b10, S3, BL, 20, 1'b0, 1'b0, 1'b1);

    bus.i_data0 = 8'h3A;
    bus.i_mode0 = MODE_EVEN;
    bus.i_req   = 2'b01;
    run_grant("even0", 2'b01, BL, SA, 20, 1'b0, 1'b0, 1'b1);

    bus.i_data1 = 8'h07;
    bus.i_mode1 = MODE_SPIN;
    bus.i_req   = 2'b10;
    run_grant("spin1", 2'b10, 7'h3F, 7'h5F, 20, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
